// File: rtl/gba_mem_pkg.sv
// gba_mem_pkg: bus access size encoding, page field location and FSM state type for the memory system
package gba_mem_pkg;

   typedef logic [1:0] mem_size_t;

   localparam mem_size_t MEM_SIZE_BYTE = 2'd0;
   localparam mem_size_t MEM_SIZE_HALF = 2'd1;
   localparam mem_size_t MEM_SIZE_WORD = 2'd2;
   localparam mem_size_t MEM_SIZE_RESR = 2'd3;

   localparam int PAGE_LSB = 24;
   localparam int PAGE_MSB = 27;

   typedef enum logic {WS_IDLE, WS_STALL} ws_state_t;

   // reserved size counts as a word so a following access can still chain onto it
   function automatic logic [2:0] size_bytes(input mem_size_t s);
      return (s == MEM_SIZE_BYTE) ? 3'd1 : (s == MEM_SIZE_HALF) ? 3'd2 : 3'd4;
   endfunction

endpackage

// File: rtl/ws_counter.sv
// ws_counter: load/decrement wait counter; pause doubles as the stall-cycle enable
module ws_counter
   import gba_mem_pkg::*;
#(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             pause
);

   ws_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // state and count registers, cleared immediately by reset so a stall is cut short
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WS_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // load only from idle (caller never loads while stalled), count down while stalled
   always_comb begin
      cnt_nx   = (state == WS_STALL) ? cnt - CNT_W'(1) : (load ? load_val : cnt);
      state_nx = (state == WS_STALL) ? ((cnt == CNT_W'(1)) ? WS_IDLE : WS_STALL)
                                     : ((load && load_val != '0) ? WS_STALL : WS_IDLE);
   end

   // pause comes straight from the state flop
   always_comb begin
      pause = (state == WS_STALL);
   end

endmodule

// File: rtl/wait_state_ctrl.sv
// wait_state_ctrl: per-page N/S wait-state generator with read-only write abort; stats counters built only with WAIT_STATE_STATS_EN
module wait_state_ctrl
   import gba_mem_pkg::*;
#(
   parameter int NUM_PAGES      = 16,
   parameter int CNT_W          = 3,
   parameter int SEQ_BOUND_LOG2 = 17
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req,
   input  logic [31:0]                addr,
   input  logic [1:0]                 size,
   input  logic                       write,
   input  logic [NUM_PAGES*CNT_W-1:0] wait_n,
   input  logic [NUM_PAGES*CNT_W-1:0] wait_s,
   input  logic [NUM_PAGES-1:0]       ro_mask,
   output logic                       pause,
   output logic                       abort,
   output logic                       seq,
   output logic                       size_err,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                n_cnt,
   output logic [31:0]                s_cnt
);

   localparam logic [4:0] NP = 5'(NUM_PAGES);

   logic             accept, page_ok, is_seq, chain_v;
   logic [3:0]       page, idx;
   logic [CNT_W-1:0] wcnt;
   logic [31:0]      prev_addr;
   mem_size_t        prev_size;

   // classify the presented access and pick its wait count
   always_comb begin
      accept  = req && !pause;
      page    = addr[PAGE_MSB:PAGE_LSB];
      page_ok = {1'b0, page} < NP;
      idx     = page_ok ? page : '0;
      is_seq  = chain_v && page_ok && (size != MEM_SIZE_RESR)
                && (addr == prev_addr + 32'(size_bytes(prev_size)))
                && (page == prev_addr[PAGE_MSB:PAGE_LSB])
                && (addr[SEQ_BOUND_LOG2-1:0] != '0);
      wcnt    = !page_ok ? '0 : is_seq ? wait_s[int'(idx)*CNT_W +: CNT_W]
                                       : wait_n[int'(idx)*CNT_W +: CNT_W];
   end

   ws_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .load_val (wcnt),
      .pause    (pause)
   );

   // chain tracking and one-cycle flags; an idle slot with pause low breaks the chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_v   <= 1'b0;
         prev_addr <= '0;
         prev_size <= MEM_SIZE_BYTE;
         seq       <= 1'b0;
         abort     <= 1'b0;
         size_err  <= 1'b0;
      end else begin
         abort    <= accept && write && page_ok && ro_mask[idx];
         size_err <= accept && (size == MEM_SIZE_RESR);
         if (!pause) chain_v <= req;
         if (accept) begin
            prev_addr <= addr;
            prev_size <= size;
            seq       <= is_seq;
         end
      end
   end

`ifdef WAIT_STATE_STATS_EN
   // saturating statistics counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         n_cnt     <= '0;
         s_cnt     <= '0;
      end else begin
         if (pause && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
         if (accept && !is_seq && n_cnt != '1) n_cnt <= n_cnt + 32'd1;
         if (accept && is_seq && s_cnt != '1) s_cnt <= s_cnt + 32'd1;
      end
   end
`else
   assign stall_cnt = '0;
   assign n_cnt     = '0;
   assign s_cnt     = '0;
`endif

endmodule
